// File: rtl/tff_counter_ctrl_pkg.sv
// tff_counter_ctrl_pkg: shared state encoding and default width for the toggle-bank counter
package tff_counter_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/tff_counter_ctrl_cell.sv
// tff_cell: single toggle flip-flop with synchronous active-high reset
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk) q <= rst ? 1'b0 : q ^ t;
endmodule

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: sequences a bank of toggle cells as a programmable up/down modulo counter
module tff_counter_ctrl
  import tff_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             up_dn,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mod;
  logic             r_dir;
  logic [WIDTH-1:0] w_t, w_step, w_init, w_term;
  logic             w_at_term;
  assign w_init    = r_dir ? '0 : r_mod;
  assign w_term    = r_dir ? r_mod : '0;
  assign w_at_term = count == w_term;
  assign busy      = r_state != ST_IDLE;
  assign done      = r_state == ST_DONE;
  // A bit toggles on a step once every lower bit is at its carry/borrow value
  assign w_step[0] = 1'b1;
  genvar i;
  for (i = 1; i < WIDTH; i++) begin : g_step
    assign w_step[i] = r_dir ? &count[i-1:0] : ~|count[i-1:0];
  end
  for (i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (.clk(clk), .rst(rst), .t(w_t[i]), .q(count[i]));
  end
  always_comb begin
    w_next = r_state;
    w_t    = '0;
    case (r_state)
      ST_IDLE: w_next = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        w_next = abort ? ST_IDLE : ST_RUN;
        w_t    = abort ? '0 : count ^ w_init;
      end
      ST_RUN: begin
        w_next = abort ? ST_IDLE : w_at_term ? ST_DONE : ST_RUN;
        w_t    = (abort || w_at_term || pause) ? '0 : w_step;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? ST_IDLE : w_next;
    if (rst) begin
      r_mod <= '0;
      r_dir <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_mod <= mod_val;
      r_dir <= up_dn;
    end
  end
endmodule
